// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter fed by a small circular TX FIFO.
// Status outputs (count/full/empty/busy) are all registered for the IO status register.
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [CW-1:0] count_nxt;
    logic          push, pop, drop;

    // Full/empty come from the registered count, so push/drop decisions use pre-edge state.
    assign push = wr_en && !fifo_full;
    assign drop = wr_en && fifo_full;
    assign pop  = (state == IDLE) && !fifo_empty;

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)
            count_nxt = fifo_count + 1'b1;
        else if (pop && !push)
            count_nxt = fifo_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            fifo_count <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == CW'(FIFO_DEPTH));
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            // tx/busy are loaded with the value belonging to the state being entered.
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rptr];
                        timer <= T_RELOAD;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        timer   <= T_RELOAD;
                        tx      <= shift[0];
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= T_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: timeline reference model (queue + frame start times) and a serial receiver.
module tb_io_uart_tx;
    localparam int C  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;
    localparam int FR = 10 * C;

    logic clk = 0, rst = 0, wr_en = 0, ovf_clr = 0;
    logic [7:0] wr_data = 0;
    logic tx, busy, fifo_full, fifo_empty, overflow;
    logic [CW-1:0] fifo_count;

    io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Reference model: edge counter, queued bytes, start edge of the current frame.
    int k = 0, free_at = 0, pstart = 0;
    bit act = 0, movf = 0;
    logic [7:0] cur;
    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    logic [CW+4:0] exp_vec;
    wire  [CW+4:0] obs = {tx, busy, fifo_full, fifo_empty, fifo_count, overflow};

    function automatic logic [CW+4:0] model_out();
        logic t, b;
        int j;
        j = k - pstart;
        b = act && (j < FR);
        t = 1'b1;
        if (b) begin
            if (j / C == 0) t = 1'b0;
            else if (j / C <= 8) t = cur[j / C - 1];
        end
        return {t, b, mq.size() == D, mq.size() == 0, CW'(mq.size()), movf};
    endfunction

    task automatic tick(input bit r, input bit w, input logic [7:0] d, input bit c);
        bit pop, full;
        rst = r; wr_en = w; wr_data = d; ovf_clr = c;
        @(posedge clk);
        k++;
        if (r) begin
            mq.delete(); movf = 0; act = 0; free_at = k + 1;
        end else begin
            full = (mq.size() == D);
            pop  = (k >= free_at) && (mq.size() != 0);
            if (w && full) movf = 1;
            else if (c) movf = 0;
            if (pop) begin
                cur = mq.pop_front(); pstart = k; free_at = k + FR + 1; act = 1;
                exp_rx.push_back(cur);
            end
            if (w && !full) mq.push_back(d);
        end
        @(negedge clk);
        rst = 0; wr_en = 0; ovf_clr = 0;
        exp_vec = model_out();
    endtask

    function automatic bit model_busy();
        return (mq.size() != 0) || (act && (k - pstart < FR + 1));
    endfunction

    // Serial receiver: samples mid-bit, accepts a byte only with a valid stop bit.
    logic [7:0] rx_q[$];
    int mcnt;
    bit mact = 0;
    logic [7:0] msh;
    always @(negedge clk) begin
        if (rst) mact = 0;
        else if (!mact) begin
            if (tx === 1'b0) begin mact = 1; mcnt = 0; end
        end else begin
            mcnt++;
            if (mcnt % C == C / 2) begin
                if (mcnt / C >= 1 && mcnt / C <= 8) msh[mcnt / C - 1] = tx;
                else if (mcnt / C == 9) begin
                    mact = 0;
                    if (tx === 1'b1) rx_q.push_back(msh);
                end
            end
        end
    end

    task automatic test_reset();
        tick(1, 0, 8'h00, 0);
        tick(1, 0, 8'h00, 0);
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, CW'(0), 1'b0}) begin
            n_err++; $display("FAIL reset got %b exp %b", obs, {1'b1, 1'b0, 1'b0, 1'b1, CW'(0), 1'b0});
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    task automatic test_single(input logic [7:0] b);
        int first_low = -1, busy_cyc = 0;
        tick(0, 1, b, 0);
        for (int n = 1; n <= FR + 4; n++) begin
            if (n > 1) tick(0, 0, 8'h00, 0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL single b=%h n=%0d got %b exp %b", b, n, obs, exp_vec);
            end
            if (tx === 1'b0 && first_low < 0) first_low = n;
            if (busy === 1'b1) busy_cyc++;
        end
        n_cmp++;
        if (first_low != 2 || busy_cyc != FR) begin
            n_err++; $display("FAIL single_timing first_low=%0d busy=%0d exp 2/%0d", first_low, busy_cyc, FR);
        end
        n_cmp++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            n_err++; $display("FAIL single_rx size=%0d got %h exp %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    task automatic test_back_to_back();
        int n_fall = -1, n_rise = -1;
        bit prev_busy = 0;
        tick(0, 1, 8'h00, 0);
        tick(0, 1, 8'hFF, 0);
        for (int n = 3; n <= 2 * FR + 6; n++) begin
            tick(0, 0, 8'h00, 0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL b2b n=%0d got %b exp %b", n, obs, exp_vec);
            end
            if (prev_busy && !busy && n_fall < 0) n_fall = n;
            if (!prev_busy && busy && n_fall >= 0 && n_rise < 0) n_rise = n;
            prev_busy = busy;
        end
        n_cmp++;
        if (n_rise - n_fall != 1) begin
            n_err++; $display("FAIL b2b_gap got %0d exp 1", n_rise - n_fall);
        end
        n_cmp++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
            n_err++; $display("FAIL b2b_rx size=%0d exp 2 bytes 00 ff", rx_q.size());
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 8'h10 + 8'(i), 0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL fill i=%0d got %b exp %b", i, obs, exp_vec);
            end
        end
        n_cmp++;
        if ({fifo_full, overflow, fifo_count} !== {1'b1, 1'b1, CW'(8)}) begin
            n_err++; $display("FAIL fill_full got full=%b ovf=%b cnt=%0d exp 1/1/8", fifo_full, overflow, fifo_count);
        end
    endtask

    task automatic test_clear_and_drop();
        int n;
        tick(0, 1, 8'hEE, 1);
        n_cmp++;
        if ({overflow, fifo_count} !== {1'b1, CW'(8)} || obs !== exp_vec) begin
            n_err++; $display("FAIL clr_drop got ovf=%b cnt=%0d exp 1/8", overflow, fifo_count);
        end
        tick(0, 0, 8'h00, 1);
        n_cmp++;
        if (overflow !== 1'b0 || obs !== exp_vec) begin
            n_err++; $display("FAIL ovf_clr got %b exp 0", overflow);
        end
        for (n = 0; n < 2000 && model_busy(); n++) begin
            tick(0, 0, 8'h00, 0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL fill_drain k=%0d got %b exp %b", k, obs, exp_vec);
            end
        end
        n_cmp++;
        if (n >= 2000) begin n_err++; $display("FAIL fill_drain_timeout got %0d exp <2000", n); end
        n_cmp++;
        if (rx_q.size() != 9) begin
            n_err++; $display("FAIL fill_rx_size got %0d exp 9", rx_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_cmp++;
                if (rx_q[i] !== 8'h10 + 8'(i)) begin
                    n_err++; $display("FAIL fill_rx i=%0d got %h exp %h", i, rx_q[i], 8'h10 + 8'(i));
                end
            end
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        tick(0, 1, 8'hA5, 0);
        for (n = 0; n < 200 && !(act && k - pstart == 4 * C + 1); n++) tick(0, 0, 8'h00, 0);
        n_cmp++;
        if (n >= 200 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_reach got busy=%b exp 1", busy); end
        tick(1, 0, 8'h00, 0);
        n_cmp++;
        if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, CW'(0), 1'b0} || obs !== exp_vec) begin
            n_err++; $display("FAIL rstmid got %b exp %b", obs, exp_vec);
        end
        for (int i = 0; i < 50; i++) begin
            tick(0, 0, 8'h00, 0);
            n_cmp++;
            if (tx !== 1'b1 || obs !== exp_vec) begin
                n_err++; $display("FAIL rstmid_quiet i=%0d got %b exp %b", i, obs, exp_vec);
            end
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    task automatic test_pointer_wrap();
        int maxc = 0;
        logic [7:0] b;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            for (int n = 0; n <= FR; n++) begin
                tick(0, n == 0, b, 0);
                n_cmp++;
                if (obs !== exp_vec) begin
                    n_err++; $display("FAIL wrap i=%0d n=%0d got %b exp %b", i, n, obs, exp_vec);
                end
                if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            end
        end
        for (int n = 0; n < FR + 2; n++) tick(0, 0, 8'h00, 0);
        n_cmp++;
        if (maxc > 1 || overflow !== 1'b0) begin
            n_err++; $display("FAIL wrap_count got max=%0d ovf=%b exp <=1/0", maxc, overflow);
        end
        n_cmp++;
        if (rx_q.size() != 20 || rx_q != exp_rx) begin
            n_err++; $display("FAIL wrap_rx got %0d bytes exp %0d in order", rx_q.size(), exp_rx.size());
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 400; i++) begin
            tick(0, $urandom_range(2) == 0, 8'($urandom), $urandom_range(15) == 0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL random i=%0d got %b exp %b", i, obs, exp_vec);
            end
        end
        for (n = 0; n < 2000 && model_busy(); n++) begin
            tick(0, 0, 8'h00, 0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL random_drain k=%0d got %b exp %b", k, obs, exp_vec);
            end
        end
        n_cmp++;
        if (n >= 2000) begin n_err++; $display("FAIL random_drain_timeout got %0d exp <2000", n); end
        n_cmp++;
        if (rx_q.size() != exp_rx.size() || rx_q != exp_rx) begin
            n_err++; $display("FAIL random_rx got %0d bytes exp %0d in order", rx_q.size(), exp_rx.size());
        end
        rx_q.delete(); exp_rx.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_single(8'($urandom));
        test_back_to_back();
        test_fill_overflow();
        test_clear_and_drop();
        test_reset_mid_frame();
        test_pointer_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter peripheral, directly downstream of the IO register bank.
- The bank decodes CPU stores to the TX data register into a one-cycle write strobe plus byte. This block queues the byte in an 8-deep FIFO and serialises it 8N1 on the tx pin.
- Status outputs (busy, full, empty, count, overflow) are packed by the bank into the readable IO status register.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  one-cycle push strobe from IO register bank.
- wr_data  in  8  byte to queue; sampled when wr_en=1.
- ovf_clr  in  1  clears sticky overflow flag.
- tx  out  1  serial output, idle high.
- busy  out  1  1 while FSM not IDLE.
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued (registered).
- overflow  out  1  sticky: a push was dropped because FIFO full.

Behaviour:
- Reset (synchronous, rst=1 at posedge): tx=1, busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, FSM=IDLE, read/write pointers=0, bit timer=0, bit index=0.
- rst dominates all other inputs. A frame in progress is aborted and tx goes high the cycle after reset. Queued data is discarded.
- FIFO:
  - Circular buffer with pointers of width $clog2(FIFO_DEPTH), wrapping modulo FIFO_DEPTH.
  - full/empty are derived from the registered count, not from pointer compare.
  - Push when wr_en=1 and fifo_full=0 (pre-edge value): store wr_data at wptr, wptr++, count++.
  - wr_en=1 with fifo_full=0 and a simultaneous pop: count is unchanged, both pointers advance.
  - wr_en=1 with fifo_full=1: byte dropped and overflow<=1, even if a pop occurs the same cycle.
- overflow:
  - Sticky; cleared by ovf_clr=1.
  - If ovf_clr and a new drop occur in the same cycle, set wins (overflow=1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_empty=0, pop: shift register <= mem[rptr], rptr++, count--, timer<=CLKS_PER_BIT-1, go to START.
  - START: tx=0. When timer==0, go to DATA with index=0 and timer reloaded; otherwise timer--.
  - DATA: tx=shift[0] (LSB first). When timer==0: shift right, index++, reload timer. After index 7 expires, go to STOP.
  - STOP: tx=1. When timer expires, return to IDLE.
- tx is a registered output, driven from FSM state and shift[0]. No combinational path from wr_en to tx.
- Frame timing:
  - tx goes low 2 cycles after the push edge when the FSM is idle and the FIFO empty (edge 1: push; edge 2: pop into START; tx registered low at edge 2 output).
  - Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames insert exactly 1 IDLE cycle (tx=1) between the stop bit and the next start bit.
- busy=1 in START/DATA/STOP. It is registered with the state, so busy=0 during the inter-frame IDLE cycle.
- Bit timer width is $clog2(CLKS_PER_BIT); its only arithmetic is reload and decrement.

Test Plan:
- Reset mid-frame: CLKS_PER_BIT=4; push 0xA5, assert rst during DATA bit 3 → next cycle tx=1, busy=0, fifo_count=0, overflow=0; no further tx toggles for 50 cycles.
- Single byte: push 0x55 → tx low 2 cycles after push, then 1,0,1,0,1,0,1,0 each held 4 cycles, stop high 4 cycles; busy high for exactly 40 cycles; fifo_count 1→0 at pop.
- Back-to-back: push 0x00, 0xFF on consecutive cycles → two frames separated by exactly 1 high idle cycle; decoded bytes 0x00 then 0xFF.
- Fill and overflow: push 10 bytes 0x10..0x19 on consecutive cycles → first pops immediately, 8 more queue (fifo_full=1), 0x19 dropped, overflow=1. Received stream is 0x10..0x18. Pulse ovf_clr → overflow=0.
- Simultaneous clear and drop: with FIFO full, assert wr_en and ovf_clr in the same cycle → overflow stays 1; byte dropped; fifo_count unchanged.
- Pointer wrap: push 20 bytes paced at one per frame → all 20 received in order, fifo_count never exceeds 1, no overflow.
